// File: rtl/dl_bank_arbiter_if.sv
// Request/acknowledge bus and latch-bank view for dl_bank_arbiter.
// Handshake: a requester raises REQ with ADDR/D stable and holds all three until it sees
// its ACK pulse. It drops REQ on the edge that ends ACK. A REQ still high in the next IDLE
// cycle counts as a new request.
interface dl_bank_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 2
);
  localparam int N = 1 << AW;

  logic          i_A_REQ;
  logic [AW-1:0] i_A_ADDR;
  logic [DW-1:0] i_A_D;
  logic          o_A_ACK;
  logic          i_B_REQ;
  logic [AW-1:0] i_B_ADDR;
  logic [DW-1:0] i_B_D;
  logic          o_B_ACK;
  logic [N-1:0]    o_LAT_EN;
  logic [DW-1:0]   o_LAT_D;
  logic [N*DW-1:0] o_Q;
  logic            o_BUSY;

  modport master (
    output i_A_REQ, i_A_ADDR, i_A_D, i_B_REQ, i_B_ADDR, i_B_D,
    input  o_A_ACK, o_B_ACK, o_LAT_EN, o_LAT_D, o_Q, o_BUSY
  );

  modport slave (
    input  i_A_REQ, i_A_ADDR, i_A_D, i_B_REQ, i_B_ADDR, i_B_D,
    output o_A_ACK, o_B_ACK, o_LAT_EN, o_LAT_D, o_Q, o_BUSY
  );
endinterface

// File: rtl/dl_bank_arbiter.sv
// Round-robin two-port write arbiter driving a one-hot enabled bank of transparent cells.
// o_STATE exposes the sequencer state (0 IDLE, 1 WRITE, 2 ACK).
module dl_bank_arbiter #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic               i_CEN_n,
  dl_bank_arbiter_if.slave   bus,
  output logic [1:0]         o_STATE
);
  localparam int N = 1 << AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;    // 0 = A has priority on contention
  logic          side_q, side_d;  // 0 = A granted
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [N-1:0]  lat_en_q, lat_en_d;
  logic          a_ack_q, a_ack_d;
  logic          b_ack_q, b_ack_d;
  logic          busy_q, busy_d;
  logic          pick;
  logic [DW-1:0] bank_q [N];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    side_d  = side_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pick    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_A_REQ || bus.i_B_REQ) begin
          pick    = (bus.i_A_REQ && bus.i_B_REQ) ? ptr_q : bus.i_B_REQ;
          side_d  = pick;
          addr_d  = pick ? bus.i_B_ADDR : bus.i_A_ADDR;
          data_d  = pick ? bus.i_B_D : bus.i_A_D;
          ptr_d   = ~pick;
          state_d = WRITE;
        end
      end
      WRITE:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the phase.
    lat_en_d = '0;
    if (state_d == WRITE) lat_en_d[addr_d] = 1'b1;
    a_ack_d = (state_d == ACK) && !side_d;
    b_ack_d = (state_d == ACK) && side_d;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      side_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      lat_en_q <= '0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      busy_q   <= 1'b0;
      for (int k = 0; k < N; k++) bank_q[k] <= '0;
    end else if (!i_CEN_n) begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      side_q   <= side_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      lat_en_q <= lat_en_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
      busy_q   <= busy_d;
      // The enable closing at the end of WRITE captures the presented data.
      if (state_q == WRITE) bank_q[addr_q] <= data_q;
    end
  end

  // Enabled entry is transparent: it shows the presented data rather than its stored value.
  always_comb begin
    bus.o_Q = '0;
    for (int k = 0; k < N; k++) begin
      bus.o_Q[k*DW +: DW] = lat_en_q[k] ? data_q : bank_q[k];
    end
  end

  assign bus.o_LAT_EN = lat_en_q;
  assign bus.o_LAT_D  = data_q;
  assign bus.o_A_ACK  = a_ack_q;
  assign bus.o_B_ACK  = b_ack_q;
  assign bus.o_BUSY   = busy_q;
  assign o_STATE      = state_q;
endmodule

// File: tb/tb_dl_bank_arbiter.sv
// Directed bench for dl_bank_arbiter: a vector table for the basic sequences plus
// hand-written stall, dropped-request, pointer and reset-abort sequences.
module tb_dl_bank_arbiter;
  logic       clk;
  logic       rst;
  logic       cen_n;
  logic [1:0] dbg_state;

  dl_bank_arbiter_if #(.DW(8), .AW(2)) bus_if ();

  dl_bank_arbiter #(.DW(8), .AW(2)) dut (
    .i_CLK   (clk),
    .i_RST   (rst),
    .i_CEN_n (cen_n),
    .bus     (bus_if.slave),
    .o_STATE (dbg_state)
  );

  typedef struct {
    logic       rst;
    logic       cen_n;
    logic       a_req;
    logic [1:0] a_addr;
    logic [7:0] a_d;
    logic       b_req;
    logic [1:0] b_addr;
    logic [7:0] b_d;
    logic [3:0] lat_en;
    logic       a_ack;
    logic       b_ack;
    logic       busy;
    logic [31:0] q;
  } vec_t;

  vec_t       vecs[$];
  logic [1:0] exp_q[$];   // expected ack order: 2'b01 = A, 2'b10 = B
  int         checks;
  int         errors;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic cn,
                       input logic ar, input logic [1:0] aa, input logic [7:0] ad,
                       input logic br, input logic [1:0] ba, input logic [7:0] bd);
    rst = r;
    cen_n = cn;
    bus_if.i_A_REQ = ar;
    bus_if.i_A_ADDR = aa;
    bus_if.i_A_D = ad;
    bus_if.i_B_REQ = br;
    bus_if.i_B_ADDR = ba;
    bus_if.i_B_D = bd;
  endtask

  task automatic add(input logic r, input logic cn,
                     input logic ar, input logic [1:0] aa, input logic [7:0] ad,
                     input logic br, input logic [1:0] ba, input logic [7:0] bd,
                     input logic [3:0] len, input logic aack, input logic back,
                     input logic bsy, input logic [31:0] q);
    vec_t v;
    v.rst = r; v.cen_n = cn;
    v.a_req = ar; v.a_addr = aa; v.a_d = ad;
    v.b_req = br; v.b_addr = ba; v.b_d = bd;
    v.lat_en = len; v.a_ack = aack; v.b_ack = back; v.busy = bsy; v.q = q;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] len, input logic aack,
                            input logic back, input logic bsy, input logic [31:0] q);
    check({tag, "_lat_en"}, {28'd0, bus_if.o_LAT_EN}, {28'd0, len});
    check({tag, "_a_ack"},  {31'd0, bus_if.o_A_ACK},  {31'd0, aack});
    check({tag, "_b_ack"},  {31'd0, bus_if.o_B_ACK},  {31'd0, back});
    check({tag, "_busy"},   {31'd0, bus_if.o_BUSY},   {31'd0, bsy});
    check({tag, "_q"},      bus_if.o_Q,               q);
  endtask

  // scoreboard: ack pulses must arrive in the expected side order
  always @(negedge clk) begin
    if (!rst && (bus_if.o_A_ACK || bus_if.o_B_ACK)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ack_order: got ack %b expected none",
                 {bus_if.o_B_ACK, bus_if.o_A_ACK});
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if ({bus_if.o_B_ACK, bus_if.o_A_ACK} !== e) begin
          errors++;
          $display("FAIL ack_order: got ack %b expected %b",
                   {bus_if.o_B_ACK, bus_if.o_A_ACK}, e);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);

    // Single A write of 0xA5 to entry 2.
    add(1,0, 0,0,8'h00, 0,0,8'h00, 4'b0000,0,0,0, 32'h0000_0000);
    add(0,0, 1,2,8'hA5, 0,0,8'h00, 4'b0100,0,0,1, 32'h00A5_0000);
    add(0,0, 1,2,8'hA5, 0,0,8'h00, 4'b0000,1,0,1, 32'h00A5_0000);
    add(0,0, 0,0,8'h00, 0,0,8'h00, 4'b0000,0,0,0, 32'h00A5_0000);
    add(0,0, 0,0,8'h00, 0,0,8'h00, 4'b0000,0,0,0, 32'h00A5_0000);
    // From reset, simultaneous A (entry 0 = 0x11) and B (entry 1 = 0x22): A first.
    add(1,0, 0,0,8'h00, 0,0,8'h00, 4'b0000,0,0,0, 32'h0000_0000);
    add(0,0, 1,0,8'h11, 1,1,8'h22, 4'b0001,0,0,1, 32'h0000_0011);
    add(0,0, 1,0,8'h11, 1,1,8'h22, 4'b0000,1,0,1, 32'h0000_0011);
    add(0,0, 0,0,8'h00, 1,1,8'h22, 4'b0000,0,0,0, 32'h0000_0011);
    add(0,0, 0,0,8'h00, 1,1,8'h22, 4'b0010,0,0,1, 32'h0000_2211);
    add(0,0, 0,0,8'h00, 1,1,8'h22, 4'b0000,0,1,1, 32'h0000_2211);
    add(0,0, 0,0,8'h00, 0,0,8'h00, 4'b0000,0,0,0, 32'h0000_2211);
    // Last grant went to B, so the pointer names A for the next contended pair.
    add(0,0, 1,2,8'hC3, 1,3,8'h3C, 4'b0100,0,0,1, 32'h00C3_2211);
    add(0,0, 1,2,8'hC3, 1,3,8'h3C, 4'b0000,1,0,1, 32'h00C3_2211);
    add(0,0, 0,0,8'h00, 1,3,8'h3C, 4'b0000,0,0,0, 32'h00C3_2211);
    add(0,0, 0,0,8'h00, 1,3,8'h3C, 4'b1000,0,0,1, 32'h3CC3_2211);
    add(0,0, 0,0,8'h00, 1,3,8'h3C, 4'b0000,0,1,1, 32'h3CC3_2211);
    add(0,0, 0,0,8'h00, 0,0,8'h00, 4'b0000,0,0,0, 32'h3CC3_2211);
    // From reset, both sides write entry 3 (A 0x33, B 0x44): B's data remains.
    add(1,0, 0,0,8'h00, 0,0,8'h00, 4'b0000,0,0,0, 32'h0000_0000);
    add(0,0, 1,3,8'h33, 1,3,8'h44, 4'b1000,0,0,1, 32'h3300_0000);
    add(0,0, 1,3,8'h33, 1,3,8'h44, 4'b0000,1,0,1, 32'h3300_0000);
    add(0,0, 0,0,8'h00, 1,3,8'h44, 4'b0000,0,0,0, 32'h3300_0000);
    add(0,0, 0,0,8'h00, 1,3,8'h44, 4'b1000,0,0,1, 32'h4400_0000);
    add(0,0, 0,0,8'h00, 1,3,8'h44, 4'b0000,0,1,1, 32'h4400_0000);
    add(0,0, 0,0,8'h00, 0,0,8'h00, 4'b0000,0,0,0, 32'h4400_0000);

    exp_q.push_back(2'b01);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);

    step();
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].cen_n, vecs[i].a_req, vecs[i].a_addr, vecs[i].a_d,
            vecs[i].b_req, vecs[i].b_addr, vecs[i].b_d);
      step();
      check_outs($sformatf("v%0d", i), vecs[i].lat_en, vecs[i].a_ack, vecs[i].b_ack,
                 vecs[i].busy, vecs[i].q);
    end

    // Clock enable held high in IDLE: a pending request is not captured.
    exp_q.push_back(2'b01);
    drive(0, 1, 1, 2'd0, 8'h77, 0, 2'd0, 8'h00);
    step();
    step();
    check_outs("stall_idle", 4'b0000, 0, 0, 0, 32'h4400_0000);
    check("stall_idle_state", {30'd0, dbg_state}, 32'd0);
    // Enabled edge grants; then freeze for 4 cycles inside WRITE.
    cen_n = 1'b0;
    step();
    check_outs("stall_w0", 4'b0001, 0, 0, 1, 32'h4400_0077);
    check("stall_lat_d", {24'd0, bus_if.o_LAT_D}, 32'h77);
    cen_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_outs($sformatf("stall_w%0d", c), 4'b0001, 0, 0, 1, 32'h4400_0077);
    end
    cen_n = 1'b0;
    step();
    check_outs("stall_ack", 4'b0000, 1, 0, 1, 32'h4400_0077);
    bus_if.i_A_REQ = 1'b0;
    step();
    check_outs("stall_done", 4'b0000, 0, 0, 0, 32'h4400_0077);

    // A drops REQ during WRITE: the captured write still completes.
    exp_q.push_back(2'b01);
    drive(0, 0, 1, 2'd1, 8'h5A, 0, 2'd0, 8'h00);
    step();
    check_outs("drop_w", 4'b0010, 0, 0, 1, 32'h4400_5A77);
    bus_if.i_A_REQ = 1'b0;
    bus_if.i_A_D = 8'hFF;
    step();
    check_outs("drop_ack", 4'b0000, 1, 0, 1, 32'h4400_5A77);
    step();
    check_outs("drop_done", 4'b0000, 0, 0, 0, 32'h4400_5A77);

    // Last grant went to A, so this contended pair on entry 2 grants B first.
    exp_q.push_back(2'b10); exp_q.push_back(2'b01);
    drive(0, 0, 1, 2'd2, 8'h12, 1, 2'd2, 8'h34);
    step();
    check_outs("ptr_wb", 4'b0100, 0, 0, 1, 32'h4434_5A77);
    step();
    check_outs("ptr_ackb", 4'b0000, 0, 1, 1, 32'h4434_5A77);
    bus_if.i_B_REQ = 1'b0;
    step();
    check_outs("ptr_idle", 4'b0000, 0, 0, 0, 32'h4434_5A77);
    step();
    check_outs("ptr_wa", 4'b0100, 0, 0, 1, 32'h4412_5A77);
    step();
    check_outs("ptr_acka", 4'b0000, 1, 0, 1, 32'h4412_5A77);
    bus_if.i_A_REQ = 1'b0;
    step();
    check_outs("ptr_done", 4'b0000, 0, 0, 0, 32'h4412_5A77);

    // Reset in WRITE aborts without ACK; a held request then completes normally.
    drive(0, 0, 1, 2'd2, 8'h99, 0, 2'd0, 8'h00);
    step();
    check_outs("rst_w", 4'b0100, 0, 0, 1, 32'h4499_5A77);
    rst = 1'b1;
    #1;
    check_outs("rst_now", 4'b0000, 0, 0, 0, 32'h0000_0000);
    check("rst_lat_d", {24'd0, bus_if.o_LAT_D}, 32'h0);
    step();
    step();
    check_outs("rst_hold", 4'b0000, 0, 0, 0, 32'h0000_0000);
    exp_q.push_back(2'b01);
    rst = 1'b0;
    step();
    check_outs("rst_rw", 4'b0100, 0, 0, 1, 32'h0099_0000);
    step();
    check_outs("rst_rack", 4'b0000, 1, 0, 1, 32'h0099_0000);
    bus_if.i_A_REQ = 1'b0;
    step();
    check_outs("rst_rdone", 4'b0000, 0, 0, 0, 32'h0099_0000);

    step();
    check("ack_queue_left", exp_q.size(), 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
